// File: rtl/memo_pkg.sv
// memo_ctrl shared types and defaults.
// State encoding and default geometry of the buffer.
package memo_pkg;

   localparam int DW_DEF    = 8;
   localparam int AW_DEF    = 2;
   localparam int DEPTH_DEF = 4;
   localparam int LAT_DEF   = 1;

   typedef enum logic [1:0] {
      IDLE,
      RD_ADDR,
      RD_WAIT,
      RD_OUT
   } state_t;

endpackage

// File: rtl/memo_if.sv
// memo_ctrl bus: input stream, output stream, memory side.
// slave is the controller view, master the surrounding view.
import memo_pkg::*;

interface memo_if #(
   parameter int DW = DW_DEF,
   parameter int AW = AW_DEF
) ();
   logic          in_valid;
   logic [DW-1:0] in_data;
   logic          in_ready;
   logic          start_rd;
   logic          out_valid;
   logic [DW-1:0] out_data;
   logic          out_ready;
   logic          busy;
   logic [AW:0]   count;
   logic          mem_we;
   logic [AW-1:0] mem_dir;
   logic [DW-1:0] mem_data_in;
   logic [DW-1:0] mem_data_out;

   modport slave (
      input  in_valid, in_data, start_rd,
      input  out_ready, mem_data_out,
      output in_ready, out_valid, out_data,
      output busy, count,
      output mem_we, mem_dir, mem_data_in
   );

   modport master (
      output in_valid, in_data, start_rd,
      output out_ready, mem_data_out,
      input  in_ready, out_valid, out_data,
      input  busy, count,
      input  mem_we, mem_dir, mem_data_in
   );
endinterface

// File: rtl/My_memory.sv
// 4x8 single-port memory, synchronous write.
// Read data is registered: one cycle from dir to data_out.
module My_memory (
   input  logic       clk,
   input  logic       we,
   input  logic [1:0] dir,
   input  logic [7:0] data_in,
   output logic [7:0] data_out
);
   logic [7:0] mem [4];

   // write port and registered read port
   always_ff @(posedge clk) begin
      if (we) mem[dir] <= data_in;
      data_out <= mem[dir];
   end
endmodule

// File: rtl/memo_ctrl.sv
// Write-then-drain controller in front of a single-port memory.
// Fills consecutive words, then replays them in write order.
module memo_ctrl
   import memo_pkg::*;
#(
   parameter int DW         = DW_DEF,
   parameter int AW         = AW_DEF,
   parameter int DEPTH      = DEPTH_DEF,
   parameter int MEM_RD_LAT = LAT_DEF
) (
   input logic  clk,
   input logic  rst_n,
   memo_if.slave bus
);
   localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
   localparam logic [1:0]  LAT_M1  =
      2'((MEM_RD_LAT > 0) ? MEM_RD_LAT - 1 : 0);

   state_t        state_q, state_d;
   logic [AW-1:0] wp_q, wp_d;
   logic [AW-1:0] rp_q, rp_d;
   logic [AW:0]   cnt_q, cnt_d;
   logic          out_valid_q, out_valid_d;
   logic [DW-1:0] out_data_q, out_data_d;
   logic          busy_q, busy_d;
   logic [1:0]    wait_q, wait_d;

   logic in_ready;
   logic wr;
   logic last;

   // start_rd wins over a same-cycle byte
   assign in_ready = (state_q == IDLE) && (cnt_q < DEPTH_C)
                     && !bus.start_rd;
   assign wr   = bus.in_valid && in_ready;
   assign last = ({1'b0, rp_q} == (cnt_q - 1'b1));

   assign bus.in_ready    = in_ready;
   assign bus.mem_we      = wr && rst_n;
   assign bus.mem_dir     = (state_q == IDLE) ? wp_q : rp_q;
   assign bus.mem_data_in = bus.in_data;
   assign bus.out_valid   = out_valid_q;
   assign bus.out_data    = out_data_q;
   assign bus.busy        = busy_q;
   assign bus.count       = cnt_q;

   // next-state: fill in IDLE, address/wait/present per drained word
   always_comb begin
      state_d     = state_q;
      wp_d        = wp_q;
      rp_d        = rp_q;
      cnt_d       = cnt_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      busy_d      = busy_q;
      wait_d      = wait_q;
      unique case (state_q)
         IDLE: begin
            if (wr) begin
               wp_d  = wp_q + 1'b1;
               cnt_d = cnt_q + 1'b1;
            end
            if (bus.start_rd && cnt_q != '0) begin
               rp_d    = '0;
               busy_d  = 1'b1;
               state_d = RD_ADDR;
            end
         end
         RD_ADDR: begin
            if (MEM_RD_LAT == 0) begin
               out_data_d  = bus.mem_data_out;
               out_valid_d = 1'b1;
               state_d     = RD_OUT;
            end else begin
               wait_d  = LAT_M1;
               state_d = RD_WAIT;
            end
         end
         RD_WAIT: begin
            if (wait_q == '0) begin
               out_data_d  = bus.mem_data_out;
               out_valid_d = 1'b1;
               state_d     = RD_OUT;
            end else begin
               wait_d = wait_q - 1'b1;
            end
         end
         RD_OUT: begin
            if (bus.out_ready) begin
               out_valid_d = 1'b0;
               if (last) begin
                  cnt_d   = '0;
                  wp_d    = '0;
                  rp_d    = '0;
                  busy_d  = 1'b0;
                  state_d = IDLE;
               end else begin
                  rp_d    = rp_q + 1'b1;
                  state_d = RD_ADDR;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // state registers, cleared asynchronously
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         wp_q        <= '0;
         rp_q        <= '0;
         cnt_q       <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         busy_q      <= 1'b0;
         wait_q      <= '0;
      end else begin
         state_q     <= state_d;
         wp_q        <= wp_d;
         rp_q        <= rp_d;
         cnt_q       <= cnt_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         busy_q      <= busy_d;
         wait_q      <= wait_d;
      end
   end
endmodule

// File: tb/tb_memo_ctrl.sv
// Directed bench for memo_ctrl driving a My_memory instance.
// Inputs change 1ns after posedge; outputs are sampled at negedge.
module tb_memo_ctrl;
   logic clk;
   logic rst_n;
   int   total = 0;
   int   bad   = 0;
   int   cyc   = 0;

   memo_if #(.DW(8), .AW(2)) bus ();

   memo_ctrl #(
      .DW(8), .AW(2), .DEPTH(4), .MEM_RD_LAT(1)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   My_memory mem (
      .clk      (clk),
      .we       (bus.mem_we),
      .dir      (bus.mem_dir),
      .data_in  (bus.mem_data_in),
      .data_out (bus.mem_data_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [7:0] d);
      bus.in_valid = 1'b1;
      bus.in_data  = d;
      step();
      bus.in_valid = 1'b0;
   endtask

   task automatic wait_valid(output logic got, output int at);
      got = 1'b0;
      at  = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (bus.out_valid) begin
            got = 1'b1;
            at  = cyc;
            break;
         end
      end
   endtask

   task automatic test_reset();
      rst_n        = 1'b0;
      bus.in_valid = 1'b1;
      bus.in_data  = 8'hAA;
      bus.start_rd = 1'b0;
      bus.out_ready = 1'b0;
      #3;
      total++;
      if (bus.mem_we !== 1'b0) begin
         bad++;
         $display("FAIL rst_we: got=%b want=0", bus.mem_we);
      end
      total++;
      if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0
          || bus.count !== 3'd0) begin
         bad++;
         $display("FAIL rst_state: ov=%b busy=%b cnt=%0d want 0/0/0",
                  bus.out_valid, bus.busy, bus.count);
      end
      step();
      bus.in_valid = 1'b0;
      rst_n = 1'b1;
      @(negedge clk);
      total++;
      if (bus.in_ready !== 1'b1 || bus.count !== 3'd0) begin
         bad++;
         $display("FAIL rst_idle: rdy=%b cnt=%0d want 1/0",
                  bus.in_ready, bus.count);
      end
      step();
   endtask

   task automatic test_fill();
      for (int i = 0; i < 4; i++) begin
         bus.in_valid = 1'b1;
         bus.in_data  = 8'(3 * (i + 1));
         @(negedge clk);
         total++;
         if (bus.mem_we !== 1'b1 || bus.mem_dir !== 2'(i)
             || bus.count !== 3'(i)
             || bus.mem_data_in !== 8'(3 * (i + 1))) begin
            bad++;
            $display("FAIL fill%0d: we=%b dir=%0d cnt=%0d d=%0d want 1/%0d/%0d/%0d",
                     i, bus.mem_we, bus.mem_dir, bus.count,
                     bus.mem_data_in, i, i, 3 * (i + 1));
         end
         step();
      end
      bus.in_data = 8'd15;
      @(negedge clk);
      total++;
      if (bus.count !== 3'd4 || bus.in_ready !== 1'b0
          || bus.mem_we !== 1'b0) begin
         bad++;
         $display("FAIL fill_full: cnt=%0d rdy=%b we=%b want 4/0/0",
                  bus.count, bus.in_ready, bus.mem_we);
      end
      step();
      bus.in_valid = 1'b0;
   endtask

   task automatic test_drain();
      logic got;
      int   at;
      int   prev;
      prev = 0;
      bus.out_ready = 1'b1;
      bus.start_rd  = 1'b1;
      step();
      bus.start_rd = 1'b0;
      @(negedge clk);
      total++;
      if (bus.busy !== 1'b1 || bus.out_valid !== 1'b0) begin
         bad++;
         $display("FAIL drain_start: busy=%b ov=%b want 1/0",
                  bus.busy, bus.out_valid);
      end
      for (int k = 0; k < 4; k++) begin
         wait_valid(got, at);
         total++;
         if (!got || bus.out_data !== 8'(3 * (k + 1))) begin
            bad++;
            $display("FAIL drain_word%0d: seen=%b data=%0d want %0d",
                     k, got, bus.out_data, 3 * (k + 1));
         end
         if (k > 0) begin
            total++;
            if (at - prev != 3) begin
               bad++;
               $display("FAIL drain_gap%0d: gap=%0d want 3",
                        k, at - prev);
            end
         end
         prev = at;
      end
      @(negedge clk);
      total++;
      if (bus.busy !== 1'b0 || bus.count !== 3'd0
          || bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
         bad++;
         $display("FAIL drain_end: busy=%b cnt=%0d rdy=%b ov=%b want 0/0/1/0",
                  bus.busy, bus.count, bus.in_ready, bus.out_valid);
      end
      step();
   endtask

   task automatic test_backpressure();
      logic got;
      int   at;
      logic [7:0] exp_v [3];
      exp_v[0] = 8'd1;
      exp_v[1] = 8'd2;
      exp_v[2] = 8'd3;
      push(8'd1);
      push(8'd2);
      push(8'd3);
      bus.out_ready = 1'b0;
      bus.start_rd  = 1'b1;
      step();
      bus.start_rd = 1'b0;
      wait_valid(got, at);
      total++;
      if (!got || bus.out_data !== 8'd1) begin
         bad++;
         $display("FAIL bp_first: seen=%b data=%0d want 1",
                  got, bus.out_data);
      end
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         total++;
         if (bus.out_valid !== 1'b1 || bus.out_data !== 8'd1) begin
            bad++;
            $display("FAIL bp_hold%0d: ov=%b data=%0d want 1/1",
                     i, bus.out_valid, bus.out_data);
         end
      end
      step();
      bus.out_ready = 1'b1;
      for (int k = 0; k < 3; k++) begin
         wait_valid(got, at);
         total++;
         if (!got || bus.out_data !== exp_v[k]) begin
            bad++;
            $display("FAIL bp_word%0d: seen=%b data=%0d want %0d",
                     k, got, bus.out_data, exp_v[k]);
         end
      end
      @(negedge clk);
      total++;
      if (bus.busy !== 1'b0 || bus.count !== 3'd0) begin
         bad++;
         $display("FAIL bp_end: busy=%b cnt=%0d want 0/0",
                  bus.busy, bus.count);
      end
      step();
   endtask

   task automatic test_empty();
      bus.start_rd = 1'b1;
      @(negedge clk);
      total++;
      if (bus.in_ready !== 1'b0) begin
         bad++;
         $display("FAIL empty_prio: rdy=%b want 0", bus.in_ready);
      end
      step();
      bus.start_rd = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         total++;
         if (bus.busy !== 1'b0 || bus.out_valid !== 1'b0
             || bus.in_ready !== 1'b1) begin
            bad++;
            $display("FAIL empty%0d: busy=%b ov=%b rdy=%b want 0/0/1",
                     i, bus.busy, bus.out_valid, bus.in_ready);
         end
      end
      step();
   endtask

   task automatic test_collision();
      logic got;
      int   at;
      push(8'd10);
      push(8'd20);
      bus.out_ready = 1'b1;
      bus.in_valid  = 1'b1;
      bus.in_data   = 8'd7;
      bus.start_rd  = 1'b1;
      @(negedge clk);
      total++;
      if (bus.mem_we !== 1'b0 || bus.count !== 3'd2) begin
         bad++;
         $display("FAIL col_start: we=%b cnt=%0d want 0/2",
                  bus.mem_we, bus.count);
      end
      step();
      bus.start_rd = 1'b0;
      @(negedge clk);
      total++;
      if (bus.mem_we !== 1'b0 || bus.busy !== 1'b1) begin
         bad++;
         $display("FAIL col_busy: we=%b busy=%b want 0/1",
                  bus.mem_we, bus.busy);
      end
      wait_valid(got, at);
      total++;
      if (!got || bus.out_data !== 8'd10) begin
         bad++;
         $display("FAIL col_w0: seen=%b data=%0d want 10",
                  got, bus.out_data);
      end
      wait_valid(got, at);
      total++;
      if (!got || bus.out_data !== 8'd20) begin
         bad++;
         $display("FAIL col_w1: seen=%b data=%0d want 20",
                  got, bus.out_data);
      end
      @(negedge clk);
      total++;
      if (bus.busy !== 1'b0 || bus.mem_we !== 1'b1
          || bus.mem_dir !== 2'd0 || bus.mem_data_in !== 8'd7) begin
         bad++;
         $display("FAIL col_after: busy=%b we=%b dir=%0d d=%0d want 0/1/0/7",
                  bus.busy, bus.mem_we, bus.mem_dir, bus.mem_data_in);
      end
      step();
      bus.in_valid = 1'b0;
      @(negedge clk);
      total++;
      if (bus.count !== 3'd1) begin
         bad++;
         $display("FAIL col_cnt: cnt=%0d want 1", bus.count);
      end
      step();
   endtask

   task automatic test_reset_mid();
      logic got;
      int   at;
      bus.out_ready = 1'b0;
      bus.start_rd  = 1'b1;
      step();
      bus.start_rd = 1'b0;
      wait_valid(got, at);
      total++;
      if (!got || bus.out_data !== 8'd7) begin
         bad++;
         $display("FAIL rm_word: seen=%b data=%0d want 7",
                  got, bus.out_data);
      end
      bus.in_valid = 1'b1;
      bus.in_data  = 8'h55;
      #1;
      rst_n = 1'b0;
      #1;
      total++;
      if (bus.out_valid !== 1'b0 || bus.count !== 3'd0
          || bus.busy !== 1'b0 || bus.mem_we !== 1'b0) begin
         bad++;
         $display("FAIL rm_clear: ov=%b cnt=%0d busy=%b we=%b want 0/0/0/0",
                  bus.out_valid, bus.count, bus.busy, bus.mem_we);
      end
      step();
      rst_n = 1'b1;
      @(negedge clk);
      total++;
      if (bus.mem_we !== 1'b1 || bus.mem_dir !== 2'd0
          || bus.count !== 3'd0) begin
         bad++;
         $display("FAIL rm_refill: we=%b dir=%0d cnt=%0d want 1/0/0",
                  bus.mem_we, bus.mem_dir, bus.count);
      end
      step();
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      bus.start_rd  = 1'b1;
      step();
      bus.start_rd = 1'b0;
      wait_valid(got, at);
      total++;
      if (!got || bus.out_data !== 8'h55) begin
         bad++;
         $display("FAIL rm_drain: seen=%b data=%0h want 55",
                  got, bus.out_data);
      end
      step();
   endtask

   initial begin
      test_reset();
      test_fill();
      test_drain();
      test_backpressure();
      test_empty();
      test_collision();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/memo_ctrl.md
Name: memo_ctrl

Overview:
Controller that sits directly upstream of the 4x8 single-port memory (My_memory: clk, we, dir, data_in, data_out).
- Accepts bytes on a valid/ready input stream and writes them to consecutive addresses.
- On a read command, drains the stored bytes in write order through a valid/ready output stream.
- The memory operates as a write-then-drain buffer. Only this block drives the memory's we/dir/data_in.

Parameters:
DW, 8, data width; must match the memory width.
AW, 2, address width; must match the memory `dir` width.
DEPTH, 4, number of words used; DEPTH <= 2**AW.
MEM_RD_LAT, 1, memory read latency in cycles from `dir` applied to `data_out` valid; legal values 0..3.

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  upstream byte valid
in_data  in  DW  upstream byte
in_ready  out  1  block accepts a byte this cycle
start_rd  in  1  single-cycle pulse: drain the buffer
out_valid  out  1  out_data valid
out_data  out  DW  drained byte
out_ready  in  1  downstream accepts out_data
busy  out  1  drain in progress
count  out  AW+1  number of stored words, 0..DEPTH
mem_we  out  1  to memory `we`
mem_dir  out  AW  to memory `dir`
mem_data_in  out  DW  to memory `data_in`
mem_data_out  in  DW  from memory `data_out`

Behaviour:
- Single clock `clk`. Reset is asynchronous, active-low (`rst_n`).
- Reset values: state=IDLE, wp=0, rp=0, count=0, out_valid=0, out_data=0, busy=0. While rst_n=0, mem_we is forced to 0 regardless of in_valid.
- States: IDLE, RD_ADDR, RD_WAIT, RD_OUT.
- IDLE:
  - in_ready = (count<DEPTH) && !start_rd. start_rd has priority over a same-cycle byte.
  - Write handshake (in_valid && in_ready): mem_we=1, mem_dir=wp, mem_data_in=in_data, combinational, so the write lands on the same clk edge. Then wp++ and count++.
  - When count==DEPTH: in_ready=0, and in_valid causes no write and no state change.
  - start_rd with count>0: rp<=0, busy<=1, go to RD_ADDR.
  - start_rd with count==0: ignored. Stay in IDLE, busy stays 0.
- RD_ADDR: mem_we=0, mem_dir=rp, in_ready=0. If MEM_RD_LAT==0, capture mem_data_out into out_data, set out_valid=1, go to RD_OUT. Otherwise load the wait counter and go to RD_WAIT.
- RD_WAIT: hold mem_dir=rp for MEM_RD_LAT cycles, then capture mem_data_out into out_data, set out_valid=1, go to RD_OUT.
- RD_OUT: out_data is held stable while out_valid && !out_ready. On handshake, out_valid<=0 and:
  - if rp==count-1: go to IDLE; set count=0, wp=0, rp=0, busy=0;
  - else rp++ and go to RD_ADDR.
- start_rd outside IDLE: ignored. in_valid outside IDLE: not accepted (in_ready=0, mem_we=0).
- Outside write handshakes, mem_data_in=in_data and mem_we=0. In IDLE, mem_dir=wp.
- Pointers are AW bits. wp never exceeds DEPTH-1 at a write because of the full check, so there is no wrap within a fill. count is AW+1 bits so DEPTH is representable.
- Throughput per drained word: 1 (RD_ADDR) + MEM_RD_LAT + 1 (RD_OUT, if out_ready is high) cycles.
- rst_n asserted mid-fill or mid-drain: all state clears immediately. Stored memory contents are not cleared but are logically discarded (count=0).

Decomposition:
- Shared package memo_pkg: state encoding enum (IDLE, RD_ADDR, RD_WAIT, RD_OUT), default DW/AW/DEPTH constants.
- No sub-module is needed. The read-latency wait counter stays inline.
- The bench instantiates memo_ctrl together with My_memory.

Test Plan:
- Fill: feed 3,6,9,12 with in_valid held high -> mem_we=1 with mem_dir=0,1,2,3 on consecutive cycles. count goes 1..4. in_ready=0 after the 4th write; a 5th byte (15) is not written.
- Drain: with out_ready=1, pulse start_rd -> busy=1; out_data = 3,6,9,12 in order, each word 3 cycles apart with MEM_RD_LAT=1. Then busy=0, count=0, in_ready=1.
- Backpressure: fill 3 bytes (1,2,3), start_rd, hold out_ready=0 for 5 cycles -> out_valid=1 with out_data=1 held stable. Release -> 2,3 follow, then IDLE.
- Empty command: start_rd with count=0 -> busy stays 0, out_valid stays 0, state IDLE.
- Collision: in_valid=1 (in_data=7) and start_rd=1 in the same cycle with count=2 -> 7 is not written; the drain outputs only 2 words. 7 is accepted after the drain completes.
- Reset mid-drain: assert rst_n=0 while out_valid=1 -> out_valid=0, count=0, busy=0 immediately, mem_we=0. After release, a new fill starts at mem_dir=0.
